// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter.
// Holds the line, address and byte-select typedefs, the arbiter FSM state enum
// and the owner enum that names which cache holds the memory path.
package lc3b_types;

    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_addr;
    typedef logic [15:0]  lc3b_line_sel;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Line-wide wishbone bundle between a cache and memory.
// Signals:
//   cyc, stb, we   request strobes    (master -> slave)
//   adr            line address [15:4] (master -> slave)
//   dat_m, sel     write line, byte select (master -> slave)
//   ack            completion pulse   (slave -> master)
//   dat_s          read line          (slave -> master)
interface cache_mem_arbiter_if;
    import lc3b_types::*;

    logic          cyc;
    logic          stb;
    logic          we;
    lc3b_line_addr adr;
    lc3b_line      dat_m;
    lc3b_line_sel  sel;
    logic          ack;
    lc3b_line      dat_s;

    modport master (
        output cyc, stb, we, adr, dat_m, sel,
        input  ack, dat_s
    );

    modport slave (
        input  cyc, stb, we, adr, dat_m, sel,
        output ack, dat_s
    );

endinterface

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   i_req_i, d_req_i   requests from the I- and D-side
//   last_grant_i       side granted most recently
//   gnt_valid_o        at least one side is requesting
//   gnt_owner_o        side to grant; on a tie, the one opposite last_grant_i
module rr_arbiter2
    import lc3b_types::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  owner_t last_grant_i,
    output logic   gnt_valid_o,
    output owner_t gnt_owner_o
);

    always_comb begin
        gnt_valid_o = i_req_i | d_req_i;
        gnt_owner_o = OWN_I;
        if (i_req_i && d_req_i) begin
            gnt_owner_o = (last_grant_i == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req_i) begin
            gnt_owner_o = OWN_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one 128-bit line-wide wishbone path to memory between I- and D-cache.
// A grant latches the winner's request; it is held on the memory port until
// m_ack (or the watchdog fires), then the line goes back to the winner with a
// one-cycle ack.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   icache_if      slave port for the I-cache memory-side master
//   dcache_if      slave port for the D-cache memory-side master
//   mem_if         master port to physical memory
//   timeout_err    sticky flag, set when the watchdog forces a completion
// Parameters:
//   TIMEOUT        max BUSY cycles waiting for m_ack; 0 disables the watchdog
//   TO_W           watchdog width, TIMEOUT < 2**TO_W
module cache_mem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    cache_mem_arbiter_if.slave  icache_if,
    cache_mem_arbiter_if.slave  dcache_if,
    cache_mem_arbiter_if.master mem_if,
    output logic                timeout_err
);

    localparam logic [TO_W-1:0] TimeoutCnt = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] WdOne      = TO_W'(1);
    localparam bit              WdEn       = (TIMEOUT != 0);

    arb_state_t      state_q, state_d;
    owner_t          owner_q, owner_d;
    owner_t          last_q, last_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            we_q, we_d;
    lc3b_line_addr   adr_q, adr_d;
    lc3b_line        dat_q, dat_d;
    lc3b_line_sel    sel_q, sel_d;
    // Return buffer, split per side so each cache keeps its own last line.
    lc3b_line        i_dat_q, i_dat_d;
    lc3b_line        d_dat_q, d_dat_d;
    logic            terr_q, terr_d;

    logic            gnt_valid;
    owner_t          gnt_owner;

    rr_arbiter2 u_rr (
        .i_req_i      (icache_if.cyc & icache_if.stb),
        .d_req_i      (dcache_if.cyc & dcache_if.stb),
        .last_grant_i (last_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_owner_o  (gnt_owner)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wd_d    = wd_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        i_dat_d = i_dat_q;
        d_dat_d = d_dat_q;
        terr_d  = terr_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_owner;
                    last_d  = gnt_owner;
                    wd_d    = '0;
                    state_d = BUSY;
                    if (gnt_owner == OWN_I) begin
                        we_d  = icache_if.we;
                        adr_d = icache_if.adr;
                        dat_d = icache_if.dat_m;
                        sel_d = icache_if.sel;
                    end else begin
                        we_d  = dcache_if.we;
                        adr_d = dcache_if.adr;
                        dat_d = dcache_if.dat_m;
                        sel_d = dcache_if.sel;
                    end
                end
            end
            BUSY: begin
                if (mem_if.ack) begin
                    if (owner_q == OWN_I) i_dat_d = mem_if.dat_s;
                    else                  d_dat_d = mem_if.dat_s;
                    state_d = RESP;
                end else if (WdEn && (wd_q == TimeoutCnt)) begin
                    // Forced completion: hand back a zero line so the cache unblocks.
                    terr_d = 1'b1;
                    if (owner_q == OWN_I) i_dat_d = '0;
                    else                  d_dat_d = '0;
                    state_d = RESP;
                end else begin
                    wd_d = wd_q + WdOne;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_D;
            wd_q    <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            i_dat_q <= '0;
            d_dat_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            i_dat_q <= i_dat_d;
            d_dat_q <= d_dat_d;
            terr_q  <= terr_d;
        end
    end

    // Memory side is driven only from registers, never from the requesters.
    assign mem_if.cyc   = (state_q == BUSY);
    assign mem_if.stb   = (state_q == BUSY);
    assign mem_if.we    = we_q;
    assign mem_if.adr   = adr_q;
    assign mem_if.dat_m = dat_q;
    assign mem_if.sel   = sel_q;

    assign icache_if.ack   = (state_q == RESP) && (owner_q == OWN_I);
    assign dcache_if.ack   = (state_q == RESP) && (owner_q == OWN_D);
    assign icache_if.dat_s = i_dat_q;
    assign dcache_if.dat_s = d_dat_q;

    assign timeout_err = terr_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter (TIMEOUT=4).
module tb_cache_mem_arbiter;
    import lc3b_types::*;

    typedef struct {
        logic          we;
        lc3b_line_addr adr;
        lc3b_line      dat;
        lc3b_line_sel  sel;
        logic          chg;
        lc3b_line_addr adr2;
    } req_t;

    typedef struct {
        owner_t   side;
        lc3b_line dat;
        logic     terr;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic timeout_err;

    cache_mem_arbiter_if ibus ();
    cache_mem_arbiter_if dbus ();
    cache_mem_arbiter_if mbus ();

    cache_mem_arbiter #(
        .TIMEOUT (4),
        .TO_W    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .icache_if   (ibus),
        .dcache_if   (dbus),
        .mem_if      (mbus),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    req_t iq[$];
    req_t dq[$];
    req_t exp_mem[$];
    rsp_t exp_rsp[$];

    int n_vec = 0;
    int n_err = 0;
    int last_stb_len = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic lc3b_line mem_line(lc3b_line_addr a);
        return {8{4'hC, a}};
    endfunction

    function automatic req_t mk_req(logic we, lc3b_line_addr adr, lc3b_line dat,
                                    lc3b_line_sel sel, logic chg, lc3b_line_addr adr2);
        req_t r;
        r.we = we; r.adr = adr; r.dat = dat; r.sel = sel; r.chg = chg; r.adr2 = adr2;
        return r;
    endfunction

    task automatic issue(owner_t side, req_t r);
        if (side == OWN_I) iq.push_back(r);
        else               dq.push_back(r);
    endtask

    task automatic expect_txn(owner_t side, req_t r, lc3b_line rdat, logic terr);
        rsp_t e;
        e.side = side; e.dat = rdat; e.terr = terr;
        exp_mem.push_back(r);
        exp_rsp.push_back(e);
    endtask

    // ---------------- memory model ----------------
    logic     mem_hang = 1'b0;
    logic     mem_fixed = 1'b0;
    lc3b_line mem_fixed_dat = '0;
    int       mem_delay = 0;
    int       wait_cnt = 0;

    initial begin : memory
        mbus.ack   = 1'b0;
        mbus.dat_s = '1;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && mbus.stb && !mem_hang && wait_cnt == mem_delay) begin
                mbus.ack   = 1'b1;
                mbus.dat_s = mem_fixed ? mem_fixed_dat : mem_line(mbus.adr);
                wait_cnt   = 0;
            end else begin
                mbus.ack   = 1'b0;
                mbus.dat_s = '1;
                if (rst_n && mbus.stb && !mem_hang) wait_cnt++;
                else                                wait_cnt = 0;
            end
        end
    end

    // ---------------- requester agents ----------------
    req_t ri, rd;
    int   ni, nd;

    initial begin : i_agent
        ibus.cyc = 1'b0; ibus.stb = 1'b0; ibus.we = 1'b0;
        ibus.adr = '0; ibus.dat_m = '0; ibus.sel = '0;
        forever begin
            @(negedge clk);
            if (rst_n && iq.size() != 0) begin
                ri = iq.pop_front();
                ibus.cyc = 1'b1; ibus.stb = 1'b1; ibus.we = ri.we;
                ibus.adr = ri.adr; ibus.dat_m = ri.dat; ibus.sel = ri.sel;
                ni = 0;
                while (ni < 300) begin
                    @(negedge clk);
                    ni++;
                    if (ri.chg && ni == 2) ibus.adr = ri.adr2;
                    if (ibus.ack) break;
                end
                if (ni >= 300) chk("i_agent_ack_timeout", 128'(ibus.ack), 128'(1));
                ibus.cyc = 1'b0; ibus.stb = 1'b0;
            end
        end
    end

    initial begin : d_agent
        dbus.cyc = 1'b0; dbus.stb = 1'b0; dbus.we = 1'b0;
        dbus.adr = '0; dbus.dat_m = '0; dbus.sel = '0;
        forever begin
            @(negedge clk);
            if (rst_n && dq.size() != 0) begin
                rd = dq.pop_front();
                dbus.cyc = 1'b1; dbus.stb = 1'b1; dbus.we = rd.we;
                dbus.adr = rd.adr; dbus.dat_m = rd.dat; dbus.sel = rd.sel;
                nd = 0;
                while (nd < 300) begin
                    @(negedge clk);
                    nd++;
                    if (rd.chg && nd == 2) dbus.adr = rd.adr2;
                    if (dbus.ack) break;
                end
                if (nd >= 300) chk("d_agent_ack_timeout", 128'(dbus.ack), 128'(1));
                dbus.cyc = 1'b0; dbus.stb = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic     stb_prev = 1'b0;
    logic     ack_prev = 1'b0;
    logic     em_valid = 1'b0;
    int       stb_len = 0;
    req_t     em;
    rsp_t     er;
    lc3b_line hold_i = '0;
    lc3b_line hold_d = '0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_i = '0; hold_d = '0; stb_prev = 1'b0; ack_prev = 1'b0;
                em_valid = 1'b0; stb_len = 0;
            end else begin
                if (mbus.stb && !stb_prev) begin
                    stb_len = 0;
                    if (exp_mem.size() == 0) begin
                        em_valid = 1'b0;
                        chk("unexpected_mem_req", 128'(mbus.stb), 128'(0));
                    end else begin
                        em = exp_mem.pop_front();
                        em_valid = 1'b1;
                    end
                end
                if (mbus.stb) begin
                    stb_len++;
                    if (em_valid) begin
                        chk("m_ctl", 128'({mbus.cyc, mbus.we, mbus.adr, mbus.sel}),
                            128'({1'b1, em.we, em.adr, em.sel}));
                        chk("m_dat_m", mbus.dat_m, em.dat);
                    end
                end else if (stb_prev) begin
                    last_stb_len = stb_len;
                end
                if (ibus.ack || dbus.ack) begin
                    if (exp_rsp.size() == 0) begin
                        chk("unexpected_ack", 128'({ibus.ack, dbus.ack}), 128'(0));
                    end else begin
                        er = exp_rsp.pop_front();
                        chk("ack_side", 128'({ibus.ack, dbus.ack}),
                            (er.side == OWN_I) ? 128'(2'b10) : 128'(2'b01));
                        chk("ack_pulse", 128'(ack_prev), 128'(0));
                        chk("timeout_err_at_ack", 128'(timeout_err), 128'(er.terr));
                        if (!er.terr) chk("ack_after_m_ack", 128'(mbus.ack), 128'(1));
                        if (er.side == OWN_I) hold_i = er.dat;
                        else                  hold_d = er.dat;
                    end
                end
                chk("i_dat_s", ibus.dat_s, hold_i);
                chk("d_dat_s", dbus.dat_s, hold_d);
                stb_prev = mbus.stb;
                ack_prev = ibus.ack | dbus.ack;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_all_zero(string tag);
        chk({tag, "_m_ctl"}, 128'({mbus.cyc, mbus.stb, mbus.we, mbus.adr, mbus.sel}), '0);
        chk({tag, "_m_dat_m"}, mbus.dat_m, '0);
        chk({tag, "_acks_terr"}, 128'({ibus.ack, dbus.ack, timeout_err}), '0);
        chk({tag, "_i_dat_s"}, ibus.dat_s, '0);
        chk({tag, "_d_dat_s"}, dbus.dat_s, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_done(string tag);
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || iq.size() != 0 || dq.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk({tag, "_drain_timeout"}, 128'(exp_rsp.size()), 128'(0));
        repeat (3) @(negedge clk);
        chk({tag, "_mem_q_empty"}, 128'(exp_mem.size()), 128'(0));
    endtask

    req_t r;

    initial begin : main
        // Reset state
        #12 check_all_zero("reset_state");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Single I read, memory acks two cycles after m_stb
        mem_fixed = 1'b1; mem_fixed_dat = {16{8'hA5}}; mem_delay = 2;
        r = mk_req(1'b0, 12'h123, '0, 16'hFFFF, 1'b0, '0);
        expect_txn(OWN_I, r, {16{8'hA5}}, 1'b0);
        issue(OWN_I, r);
        wait_done("single_i_read");
        mem_fixed = 1'b0;

        // Simultaneous first request after reset: I wins, then D write
        do_reset();
        mem_delay = 0;
        r = mk_req(1'b0, 12'h010, {4{32'h1111_0010}}, 16'hFFFF, 1'b0, '0);
        expect_txn(OWN_I, r, mem_line(12'h010), 1'b0);
        issue(OWN_I, r);
        r = mk_req(1'b1, 12'h020, {4{32'hDEAD_0020}}, 16'hFFFF, 1'b0, '0);
        expect_txn(OWN_D, r, mem_line(12'h020), 1'b0);
        issue(OWN_D, r);
        wait_done("tie_after_reset");

        // Fairness: both sides keep requesting, grants alternate I, D, ...
        mem_delay = 1;
        for (int k = 0; k < 3; k++) begin
            r = mk_req(1'b0, 12'h100 + 12'(k), '0, 16'h00FF, 1'b0, '0);
            expect_txn(OWN_I, r, mem_line(12'h100 + 12'(k)), 1'b0);
            issue(OWN_I, r);
            r = mk_req(1'b1, 12'h200 + 12'(k), {4{32'hD000_0200 + 32'(k)}}, 16'hF0F0, 1'b0, '0);
            expect_txn(OWN_D, r, mem_line(12'h200 + 12'(k)), 1'b0);
            issue(OWN_D, r);
        end
        wait_done("fairness");

        // Requester changes d_adr mid-BUSY; memory must keep the latched address
        mem_delay = 3;
        r = mk_req(1'b0, 12'h040, '0, 16'hFFFF, 1'b1, 12'h041);
        issue(OWN_D, r);
        r.adr2 = 12'h040;
        expect_txn(OWN_D, r, mem_line(12'h040), 1'b0);
        wait_done("adr_change");

        // Watchdog: memory never acks
        mem_hang = 1'b1;
        r = mk_req(1'b0, 12'h300, '0, 16'hFFFF, 1'b0, '0);
        expect_txn(OWN_I, r, '0, 1'b1);
        issue(OWN_I, r);
        wait_done("timeout");
        chk("timeout_stb_cycles", 128'(last_stb_len), 128'(5));
        chk("timeout_err_sticky", 128'(timeout_err), 128'(1));
        mem_hang = 1'b0; mem_delay = 0;
        r = mk_req(1'b0, 12'h301, '0, 16'hFFFF, 1'b0, '0);
        expect_txn(OWN_D, r, mem_line(12'h301), 1'b1);
        issue(OWN_D, r);
        wait_done("after_timeout");

        // Reset during BUSY: transaction abandoned, pending D re-granted after I
        mem_hang = 1'b1;
        r = mk_req(1'b0, 12'h050, '0, 16'hFFFF, 1'b0, '0);
        exp_mem.push_back(r);
        issue(OWN_D, r);
        begin
            int n;
            n = 0;
            while (!mbus.stb && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("busy_before_reset", 128'(mbus.stb), 128'(1));
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_busy");
        mem_hang = 1'b0;
        r = mk_req(1'b0, 12'h060, '0, 16'hFFFF, 1'b0, '0);
        expect_txn(OWN_I, r, mem_line(12'h060), 1'b0);
        issue(OWN_I, r);
        r = mk_req(1'b0, 12'h050, '0, 16'hFFFF, 1'b0, '0);
        expect_txn(OWN_D, r, mem_line(12'h050), 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_done("regrant_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
